// File: rtl/coin_credit_engine_if.sv
// coin_credit_engine_if: coin/selection/price bus between a coin credit engine and its controller
//   i_input_coin     coin insertion strobe, one bit per denomination
//   i_select_item    item selection strobe
//   i_cancel         request to return all credit
//   i_coin_value     packed coin values, index 0 at LSBs, ascending
//   i_item_price     packed item prices, index 0 at LSBs
//   o_available_item items affordable with the current credit
//   o_dispense_item  one-hot vend pulse
//   o_return_coin    one-hot change coin pulse
//   o_coin_reject    echo of rejected coin bits
//   o_credit         current credit
//   o_wait_time      current inactivity counter
//   o_state          IDLE=0 CREDIT=1 VEND=2 CHANGE=3
interface coin_credit_engine_if #(
   parameter int NUM_COINS = 3,
   parameter int NUM_ITEMS = 4,
   parameter int CREDIT_W  = 32
);
   logic [NUM_COINS-1:0]          i_input_coin;
   logic [NUM_ITEMS-1:0]          i_select_item;
   logic                          i_cancel;
   logic [NUM_COINS*CREDIT_W-1:0] i_coin_value;
   logic [NUM_ITEMS*CREDIT_W-1:0] i_item_price;
   logic [NUM_ITEMS-1:0]          o_available_item;
   logic [NUM_ITEMS-1:0]          o_dispense_item;
   logic [NUM_COINS-1:0]          o_return_coin;
   logic [NUM_COINS-1:0]          o_coin_reject;
   logic [CREDIT_W-1:0]           o_credit;
   logic [CREDIT_W-1:0]           o_wait_time;
   logic [1:0]                    o_state;
   modport master (
      output i_input_coin, i_select_item, i_cancel, i_coin_value, i_item_price,
      input  o_available_item, o_dispense_item, o_return_coin, o_coin_reject,
             o_credit, o_wait_time, o_state
   );
   modport slave (
      input  i_input_coin, i_select_item, i_cancel, i_coin_value, i_item_price,
      output o_available_item, o_dispense_item, o_return_coin, o_coin_reject,
             o_credit, o_wait_time, o_state
   );
endinterface

// File: rtl/coin_credit_engine.sv
// coin_credit_engine: vending credit FSM accepting coins, vending items and paying out change
//   clk     rising-edge clock
//   reset_n synchronous active-low reset
//   bus     coin_credit_engine_if slave: coin/select/cancel inputs, value and price tables,
//           availability, dispense/return/reject pulses, credit, wait time and state outputs
module coin_credit_engine #(
   parameter int NUM_COINS   = 3,
   parameter int NUM_ITEMS   = 4,
   parameter int CREDIT_W    = 32,
   parameter int WAIT_CYCLES = 10
) (
   input logic clk,
   input logic reset_n,
   coin_credit_engine_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, CREDIT = 2'd1, VEND = 2'd2, CHANGE = 2'd3} state_t;
   localparam logic [CREDIT_W-1:0] WAIT_RELOAD = CREDIT_W'(WAIT_CYCLES);
   state_t               state, state_nx;
   logic [CREDIT_W-1:0]  credit, credit_nx, wait_time, wait_nx;
   logic [NUM_ITEMS-1:0] dispense, dispense_nx, avail, sel_req, sel_lsb;
   logic [NUM_COINS-1:0] ret, ret_nx, reject, reject_nx, coin_lsb, change_bit;
   logic [CREDIT_W-1:0]  coin_val, price_sel, change_val;
   logic [CREDIT_W:0]    sum;
   logic                 coin_ok;
   // Lowest set bit isolates the single coin that may be accepted this cycle.
   assign coin_lsb = bus.i_input_coin & (~bus.i_input_coin + NUM_COINS'(1));
   assign sel_req  = bus.i_select_item & avail;
   assign sel_lsb  = sel_req & (~sel_req + NUM_ITEMS'(1));
   assign sum      = {1'b0, credit} + {1'b0, coin_val};
   // Carry out of the sum means the credit register would overflow.
   assign coin_ok  = (|coin_lsb) && !sum[CREDIT_W];
   always_comb begin
      coin_val  = '0;
      price_sel = '0;
      avail     = '0;
      for (int i = 0; i < NUM_COINS; i++)
         if (coin_lsb[i]) coin_val = bus.i_coin_value[i*CREDIT_W +: CREDIT_W];
      for (int i = 0; i < NUM_ITEMS; i++) begin
         avail[i] = (state == CREDIT) && (credit >= bus.i_item_price[i*CREDIT_W +: CREDIT_W]);
         if (sel_lsb[i]) price_sel = bus.i_item_price[i*CREDIT_W +: CREDIT_W];
      end
   end
   // Values ascend with index, so the last coin that fits is the largest one.
   always_comb begin
      change_bit = '0;
      change_val = '0;
      for (int i = 0; i < NUM_COINS; i++)
         if (bus.i_coin_value[i*CREDIT_W +: CREDIT_W] <= credit) begin
            change_bit = NUM_COINS'(1) << i;
            change_val = bus.i_coin_value[i*CREDIT_W +: CREDIT_W];
         end
   end
   always_comb begin
      state_nx    = state;
      credit_nx   = credit;
      wait_nx     = wait_time;
      dispense_nx = '0;
      ret_nx      = '0;
      reject_nx   = bus.i_input_coin;
      if (state == IDLE || state == CREDIT) begin
         if (coin_ok) begin
            reject_nx = bus.i_input_coin & ~coin_lsb;
            credit_nx = sum[CREDIT_W-1:0];
            wait_nx   = WAIT_RELOAD;
            state_nx  = CREDIT;
         end else if (state == CREDIT) begin
            if (bus.i_cancel || wait_time == '0) state_nx = CHANGE;
            else if (|sel_lsb) begin
               state_nx    = VEND;
               credit_nx   = credit - price_sel;
               dispense_nx = sel_lsb;
            end else wait_nx = wait_time - CREDIT_W'(1);
         end
      end else if (state == VEND) begin
         wait_nx  = WAIT_RELOAD;
         state_nx = (credit != '0) ? CREDIT : IDLE;
      end else begin
         // A remainder smaller than every coin is forfeited rather than stalling here.
         ret_nx    = change_bit;
         credit_nx = (|change_bit) ? credit - change_val : '0;
         if (credit_nx == '0) begin
            state_nx = IDLE;
            wait_nx  = WAIT_RELOAD;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         credit    <= '0;
         wait_time <= WAIT_RELOAD;
         dispense  <= '0;
         ret       <= '0;
         reject    <= '0;
      end else begin
         state     <= state_nx;
         credit    <= credit_nx;
         wait_time <= wait_nx;
         dispense  <= dispense_nx;
         ret       <= ret_nx;
         reject    <= reject_nx;
      end
   end
   assign bus.o_available_item = avail;
   assign bus.o_dispense_item  = dispense;
   assign bus.o_return_coin    = ret;
   assign bus.o_coin_reject    = reject;
   assign bus.o_credit         = credit;
   assign bus.o_wait_time      = wait_time;
   assign bus.o_state          = state;
endmodule

// File: tb/tb_coin_credit_engine.sv
// tb_coin_credit_engine: scoreboard bench for coin_credit_engine (default widths plus an 11-bit credit instance)
module tb_coin_credit_engine;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   logic [9:0] sb[$];
   always #5 clk = ~clk;
   coin_credit_engine_if #(.NUM_COINS(3), .NUM_ITEMS(4), .CREDIT_W(32)) a ();
   coin_credit_engine_if #(.NUM_COINS(3), .NUM_ITEMS(4), .CREDIT_W(11)) b ();
   coin_credit_engine #(.NUM_COINS(3), .NUM_ITEMS(4), .CREDIT_W(32), .WAIT_CYCLES(10)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(a.slave));
   coin_credit_engine #(.NUM_COINS(3), .NUM_ITEMS(4), .CREDIT_W(11), .WAIT_CYCLES(10)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(b.slave));
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask
   task automatic cyc(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   // Expected pulse word layout: {dispense[3:0], return[2:0], reject[2:0]}.
   task automatic expect_pulse(input logic [3:0] d, input logic [2:0] r, input logic [2:0] j);
      sb.push_back({d, r, j});
   endtask
   always @(negedge clk) begin
      logic [9:0] obs, exp;
      obs = {a.o_dispense_item, a.o_return_coin, a.o_coin_reject};
      if (obs != '0) begin
         exp = '0;
         if (sb.size() != 0) exp = sb.pop_front();
         check("pulse", obs, exp);
      end
   end
   initial begin
      int cnt;
      a.i_input_coin  = '0;
      a.i_select_item = '0;
      a.i_cancel      = 1'b0;
      a.i_coin_value  = {32'd1000, 32'd500, 32'd100};
      a.i_item_price  = {32'd2000, 32'd1000, 32'd500, 32'd400};
      b.i_input_coin  = '0;
      b.i_select_item = '0;
      b.i_cancel      = 1'b0;
      b.i_coin_value  = {11'd1000, 11'd500, 11'd100};
      b.i_item_price  = {11'd2000, 11'd1000, 11'd500, 11'd400};
      cyc(2);
      check("rst_state", a.o_state, 0);
      check("rst_credit", a.o_credit, 0);
      check("rst_wait", a.o_wait_time, 10);
      check("rst_pulses", {a.o_dispense_item, a.o_return_coin, a.o_coin_reject}, 0);
      reset_n = 1'b1;
      // 11-bit credit: build 1900, then a 1000 coin must overflow and be rejected.
      b.i_input_coin = 3'b100; cyc();
      b.i_input_coin = 3'b010; cyc();
      b.i_input_coin = 3'b001; cyc(4);
      check("w11_credit1900", b.o_credit, 1900);
      b.i_input_coin = 3'b100; cyc();
      b.i_input_coin = 3'b000;
      check("w11_reject", b.o_coin_reject, 3'b100);
      check("w11_credit_kept", b.o_credit, 1900);
      check("w11_state", b.o_state, 1);
      // Coin 500, buy item 0 (400), leaving 100.
      a.i_input_coin = 3'b010; cyc();
      a.i_input_coin = 3'b000;
      check("t1_credit", a.o_credit, 500);
      check("t1_state", a.o_state, 1);
      check("t1_avail", a.o_available_item, 4'b0011);
      expect_pulse(4'b0001, 3'b000, 3'b000);
      a.i_select_item = 4'b0001; cyc();
      a.i_select_item = 4'b0000;
      check("t1_vend_state", a.o_state, 2);
      check("t1_vend_credit", a.o_credit, 100);
      cyc();
      check("t1_after_state", a.o_state, 1);
      check("t1_after_credit", a.o_credit, 100);
      check("t1_after_wait", a.o_wait_time, 10);
      expect_pulse(4'b0000, 3'b001, 3'b000);
      a.i_cancel = 1'b1; cyc();
      a.i_cancel = 1'b0;
      check("t1_change", a.o_state, 3);
      cyc();
      check("t1_idle", a.o_state, 0);
      check("t1_zero", a.o_credit, 0);
      // 1000 + 500 then timeout: 10 decrements, then CHANGE on the 11th idle edge.
      a.i_input_coin = 3'b100; cyc();
      a.i_input_coin = 3'b010; cyc();
      a.i_input_coin = 3'b000;
      check("t2_credit", a.o_credit, 1500);
      expect_pulse(4'b0000, 3'b100, 3'b000);
      expect_pulse(4'b0000, 3'b010, 3'b000);
      cnt = 0;
      while (a.o_state != 2'd3 && cnt < 40) begin
         cyc();
         cnt++;
      end
      check("t2_timeout_cycles", cnt, 11);
      cyc();
      check("t2_credit_mid", a.o_credit, 500);
      cyc();
      check("t2_credit_end", a.o_credit, 0);
      check("t2_idle", a.o_state, 0);
      check("t2_wait_idle", a.o_wait_time, 10);
      // Unaffordable item is ignored, cancel returns a single 500.
      a.i_input_coin = 3'b010; cyc();
      a.i_input_coin = 3'b000;
      a.i_select_item = 4'b1000; cyc();
      a.i_select_item = 4'b0000;
      check("t3_state", a.o_state, 1);
      check("t3_credit", a.o_credit, 500);
      expect_pulse(4'b0000, 3'b010, 3'b000);
      a.i_cancel = 1'b1; cyc();
      a.i_cancel = 1'b0;
      cyc();
      check("t3_idle", a.o_state, 0);
      // Two coins at once: lowest accepted, the other rejected.
      expect_pulse(4'b0000, 3'b000, 3'b100);
      a.i_input_coin = 3'b101; cyc();
      a.i_input_coin = 3'b000;
      check("t4_credit", a.o_credit, 100);
      check("t4_state", a.o_state, 1);
      expect_pulse(4'b0000, 3'b001, 3'b000);
      a.i_cancel = 1'b1; cyc();
      a.i_cancel = 1'b0;
      cyc();
      check("t4_idle", a.o_state, 0);
      // Select and cancel in IDLE do nothing.
      a.i_select_item = 4'b1111;
      a.i_cancel = 1'b1;
      cyc(2);
      a.i_select_item = 4'b0000;
      a.i_cancel = 1'b0;
      check("t5_state", a.o_state, 0);
      check("t5_wait", a.o_wait_time, 10);
      // Coin arriving during VEND is rejected.
      a.i_input_coin = 3'b010; cyc();
      a.i_input_coin = 3'b000;
      expect_pulse(4'b0001, 3'b000, 3'b000);
      a.i_select_item = 4'b0001; cyc();
      a.i_select_item = 4'b0000;
      expect_pulse(4'b0000, 3'b000, 3'b001);
      a.i_input_coin = 3'b001; cyc();
      a.i_input_coin = 3'b000;
      check("t6_credit", a.o_credit, 100);
      check("t6_state", a.o_state, 1);
      expect_pulse(4'b0000, 3'b001, 3'b000);
      a.i_cancel = 1'b1; cyc();
      a.i_cancel = 1'b0;
      cyc();
      // Remainder 50 is below the smallest coin: cleared with no pulse.
      a.i_item_price = {32'd2000, 32'd1000, 32'd500, 32'd450};
      a.i_input_coin = 3'b010; cyc();
      a.i_input_coin = 3'b000;
      expect_pulse(4'b0001, 3'b000, 3'b000);
      a.i_select_item = 4'b0001; cyc();
      a.i_select_item = 4'b0000;
      cyc();
      check("t9_credit50", a.o_credit, 50);
      a.i_cancel = 1'b1; cyc();
      a.i_cancel = 1'b0;
      check("t9_change", a.o_state, 3);
      cyc();
      check("t9_idle", a.o_state, 0);
      check("t9_cleared", a.o_credit, 0);
      a.i_item_price = {32'd2000, 32'd1000, 32'd500, 32'd400};
      // Reset in the middle of CHANGE with 1500 credit: no change is paid.
      a.i_input_coin = 3'b100; cyc();
      a.i_input_coin = 3'b010; cyc();
      a.i_input_coin = 3'b000;
      a.i_cancel = 1'b1; cyc();
      a.i_cancel = 1'b0;
      check("t7_change", a.o_state, 3);
      check("t7_credit", a.o_credit, 1500);
      reset_n = 1'b0; cyc();
      check("t7_rst_credit", a.o_credit, 0);
      check("t7_rst_state", a.o_state, 0);
      check("t7_rst_wait", a.o_wait_time, 10);
      reset_n = 1'b1;
      cyc(4);
      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
